// File: rtl/cpu_defs.sv
// Shared memory-op encodings for the decode/execute/memory stages.
// Also holds the lane-offset and alignment helpers used by cpu_memory.
package cpu_defs;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } mem_state_e;

  // Low address bits that actually pick lanes; bits a wider access ignores are forced to zero.
  function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_SIZE_BYTE: return lo;
      MEM_SIZE_HALF: return {lo[1], 1'b0};
      default:       return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_SIZE_BYTE: return 1'b0;
      MEM_SIZE_HALF: return lo[0];
      default:       return (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/cpu_memory_if.sv
// Wishbone classic bus between the memory stage (master) and the data memory (slave).
interface cpu_memory_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [31:0]           wb_dat_o;
  logic [31:0]           wb_dat_i;
  logic [3:0]            wb_sel_o;
  logic                  wb_we_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/cpu_memory_lane.sv
// Big-endian byte-lane steering: select mask, store replication and load zero-extension.
module cpu_memory_lane
  import cpu_defs::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_data,
  output logic [3:0]  o_sel,
  output logic [31:0] o_store_data,
  output logic [31:0] o_load_data
);

  logic [1:0] w_lo;

  assign w_lo = lane_offset(i_size, i_addr_lo);

  always_comb begin
    o_sel        = 4'b1111;
    o_store_data = i_store_data;
    o_load_data  = i_load_data;
    case (i_size)
      MEM_SIZE_BYTE: begin
        o_sel        = 4'b1000 >> w_lo;
        o_store_data = {4{i_store_data[7:0]}};
        // Address byte 0 lives in the most significant lane
        case (w_lo)
          2'd0:    o_load_data = {24'h0, i_load_data[31:24]};
          2'd1:    o_load_data = {24'h0, i_load_data[23:16]};
          2'd2:    o_load_data = {24'h0, i_load_data[15:8]};
          default: o_load_data = {24'h0, i_load_data[7:0]};
        endcase
      end
      MEM_SIZE_HALF: begin
        o_sel        = w_lo[1] ? 4'b0011 : 4'b1100;
        o_store_data = {2{i_store_data[15:0]}};
        o_load_data  = w_lo[1] ? {16'h0, i_load_data[15:0]} : {16'h0, i_load_data[31:16]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_memory.sv
// Memory stage: register-file pass-through plus Wishbone load/store sequencing.
// Optional macro CPU_MEMORY_ALIGN_CHECK_EN rejects misaligned HALF/WORD accesses.
//   state   | meaning
//   ST_IDLE | accept next op; pass ALU result or launch a bus cycle
//   ST_BUS  | cyc/stb asserted, wb_* held, waiting for wb_ack_i
module cpu_memory
  import cpu_defs::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [1:0]            mem_op_i,
  input  logic [1:0]            mem_size_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [31:0]           store_data_i,
  input  logic [31:0]           result_i,
  input  logic                  register_write_enable_i,
  input  logic [3:0]            register_write_index_i,
  output logic                  register_write_enable_o,
  output logic [3:0]            register_write_index_o,
  output logic [31:0]           result_o,
  output logic                  stall_o,
  output logic                  misalign_o,
  cpu_memory_if.master          wb
);

  mem_state_e r_state, w_state_nxt;

  logic                  r_rwe;
  logic [3:0]            r_ridx;
  logic [31:0]           r_result;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [31:0]           r_dat;
  logic [3:0]            r_sel;
  logic                  r_we;
  logic                  r_cyc;
  logic [1:0]            r_op;
  logic [1:0]            r_size;
  logic [1:0]            r_lo;
  logic                  r_rwe_hold;
  logic [3:0]            r_ridx_hold;

  logic        w_is_mem;
  logic        w_misalign;
  logic        w_start;
  logic        w_stall;
  logic [1:0]  w_lane_size;
  logic [1:0]  w_lane_lo;
  logic [3:0]  w_sel;
  logic [31:0] w_store;
  logic [31:0] w_load;

  assign w_is_mem = valid_i && ((mem_op_i == MEM_OP_LOAD) || (mem_op_i == MEM_OP_STORE));

`ifdef CPU_MEMORY_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_misalign = w_is_mem && is_misaligned(mem_size_i, address_i[1:0]);

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_misalign <= 1'b0;
    else        r_misalign <= (r_state == ST_IDLE) && w_misalign;
  end

  assign misalign_o = r_misalign;
`else
  assign w_misalign = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign w_start = w_is_mem && !w_misalign;

  // One lane unit serves both phases: request steering in IDLE, load extraction in BUS
  assign w_lane_size = (r_state == ST_IDLE) ? mem_size_i      : r_size;
  assign w_lane_lo   = (r_state == ST_IDLE) ? address_i[1:0] : r_lo;

  cpu_memory_lane u_lane (
    .i_size       (w_lane_size),
    .i_addr_lo    (w_lane_lo),
    .i_store_data (store_data_i),
    .i_load_data  (wb.wb_dat_i),
    .o_sel        (w_sel),
    .o_store_data (w_store),
    .o_load_data  (w_load)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = w_start;
        if (w_start) w_state_nxt = ST_BUS;
      end
      ST_BUS: begin
        w_stall = !wb.wb_ack_i;
        if (wb.wb_ack_i) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign stall_o = rst_i && w_stall;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_rwe       <= 1'b0;
      r_ridx      <= 4'h0;
      r_result    <= 32'h0;
      r_adr       <= '0;
      r_dat       <= 32'h0;
      r_sel       <= 4'h0;
      r_we        <= 1'b0;
      r_cyc       <= 1'b0;
      r_op        <= 2'b00;
      r_size      <= 2'b00;
      r_lo        <= 2'b00;
      r_rwe_hold  <= 1'b0;
      r_ridx_hold <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_rwe   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_adr       <= {address_i[ADDR_WIDTH-1:2], 2'b00};
            r_sel       <= w_sel;
            r_dat       <= w_store;
            r_we        <= (mem_op_i == MEM_OP_STORE);
            r_cyc       <= 1'b1;
            r_op        <= mem_op_i;
            r_size      <= mem_size_i;
            r_lo        <= address_i[1:0];
            r_rwe_hold  <= register_write_enable_i;
            r_ridx_hold <= register_write_index_i;
          end else if (valid_i && !w_is_mem) begin
            r_rwe    <= register_write_enable_i;
            r_ridx   <= register_write_index_i;
            r_result <= result_i;
          end
        end
        ST_BUS: begin
          if (wb.wb_ack_i) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            if (r_op == MEM_OP_LOAD) begin
              r_rwe    <= r_rwe_hold;
              r_ridx   <= r_ridx_hold;
              r_result <= w_load;
            end
          end
        end
      endcase
    end
  end

  assign register_write_enable_o = r_rwe;
  assign register_write_index_o  = r_ridx;
  assign result_o                = r_result;

  assign wb.wb_adr_o = r_adr;
  assign wb.wb_dat_o = r_dat;
  assign wb.wb_sel_o = r_sel;
  assign wb.wb_we_o  = r_we;
  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_cyc;

endmodule

// File: tb/tb_cpu_memory.sv
// Bench for cpu_memory: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations. Honours CPU_MEMORY_ALIGN_CHECK_EN.
module tb_cpu_memory;
  import cpu_defs::*;

  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          valid;
  logic [1:0]    op;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [31:0]   sdata;
  logic [31:0]   res_i;
  logic          rwe_i;
  logic [3:0]    ridx_i;
  logic          rwe_o;
  logic [3:0]    ridx_o;
  logic [31:0]   res_o;
  logic          stall;
  logic          mis;
  logic          ack;
  logic [31:0]   rd;

  cpu_memory_if #(.ADDR_WIDTH(AW)) wb ();
  assign wb.wb_ack_i = ack;
  assign wb.wb_dat_i = rd;

  cpu_memory #(.ADDR_WIDTH(AW)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .valid_i                 (valid),
    .mem_op_i                (op),
    .mem_size_i              (size),
    .address_i               (addr),
    .store_data_i            (sdata),
    .result_i                (res_i),
    .register_write_enable_i (rwe_i),
    .register_write_index_i  (ridx_i),
    .register_write_enable_o (rwe_o),
    .register_write_index_o  (ridx_o),
    .result_o                (res_o),
    .stall_o                 (stall),
    .misalign_o              (mis),
    .wb                      (wb)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (spec rules, byte-array arithmetic) ----------------
  function automatic bit f_is_mem(input logic [1:0] o);
    return (o == 2'd1) || (o == 2'd2);
  endfunction

  function automatic bit f_mis(input logic [1:0] s, input logic [1:0] a);
`ifdef CPU_MEMORY_ALIGN_CHECK_EN
    return (s == 2'd1 && a[0]) || (s == 2'd2 && a != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int f_eff(input logic [1:0] s, input logic [1:0] a);
    if (s == 2'd0) return int'(a);
    if (s == 2'd1) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [3:0] f_sel(input logic [1:0] s, input logic [1:0] a);
    int e = f_eff(s, a);
    if (s == 2'd0) return 4'(1 << (3 - e));
    if (s == 2'd1) return (e == 0) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] f_store(input logic [1:0] s, input logic [31:0] d);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = d[31-8*i -: 8];
    if (s == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (s == 2'd1) return {b[2], b[3], b[2], b[3]};
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] s, input logic [1:0] a, input logic [31:0] d);
    logic [7:0] b [4];
    int e = f_eff(s, a);
    for (int i = 0; i < 4; i++) b[i] = d[31-8*i -: 8];
    if (s == 2'd0) return {24'h0, b[e]};
    if (s == 2'd1) return {16'h0, b[e], b[e+1]};
    return d;
  endfunction

  bit          m_on = 1'b0;
  bit          m_busy, m_we, m_cyc, m_wbwe, m_mis;
  logic [3:0]  m_idx, m_sel;
  logic [31:0] m_res, m_adr, m_dat;
  logic [1:0]  h_op, h_size, h_lo;
  logic        h_we;
  logic [3:0]  h_idx;

  always @(posedge clk) begin
    if (!rst) begin
      m_on = 1'b1; m_busy = 0; m_we = 0; m_cyc = 0; m_wbwe = 0; m_mis = 0;
      m_idx = 0; m_res = 0; m_adr = 0; m_sel = 0; m_dat = 0;
    end else if (m_on) begin
      m_mis = 0;
      m_we  = 0;
      if (m_busy) begin
        if (ack) begin
          m_busy = 0;
          m_cyc  = 0;
          if (h_op == 2'd1) begin
            m_we  = h_we;
            m_idx = h_idx;
            m_res = f_load(h_size, h_lo, rd);
          end
        end
      end else if (valid && f_is_mem(op)) begin
        if (f_mis(size, addr[1:0])) m_mis = 1;
        else begin
          m_busy = 1; m_cyc = 1;
          m_adr  = addr & ~32'h3;
          m_sel  = f_sel(size, addr[1:0]);
          m_dat  = f_store(size, sdata);
          m_wbwe = (op == 2'd2);
          h_op = op; h_size = size; h_lo = addr[1:0]; h_we = rwe_i; h_idx = ridx_i;
        end
      end else if (valid) begin
        m_we = rwe_i; m_idx = ridx_i; m_res = res_i;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("we_o", 32'(rwe_o), 32'(m_we));
      if (m_we) begin
        chk("index_o", 32'(ridx_o), 32'(m_idx));
        chk("result_o", res_o, m_res);
      end
      chk("cyc", 32'(wb.wb_cyc_o), 32'(m_cyc));
      chk("stb", 32'(wb.wb_stb_o), 32'(m_cyc));
      if (m_cyc) begin
        chk("adr", wb.wb_adr_o, m_adr);
        chk("sel", 32'(wb.wb_sel_o), 32'(m_sel));
        chk("wb_we", 32'(wb.wb_we_o), 32'(m_wbwe));
        if (m_wbwe) chk("dat_o", wb.wb_dat_o, m_dat);
      end
      chk("misalign", 32'(mis), 32'(m_mis));
      chk("stall", 32'(stall),
          32'(rst && (m_busy ? !ack : (valid && f_is_mem(op) && !f_mis(size, addr[1:0])))));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_b [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_b[0] = 32'h000000AA; exp_b[1] = 32'h000000BB;
    exp_b[2] = 32'h000000CC; exp_b[3] = 32'h000000DD;
    rst = 0; valid = 0; op = 0; size = 0; addr = 0; sdata = 0;
    res_i = 0; rwe_i = 0; ridx_i = 0; ack = 0; rd = 0;
    step(); step();
    chk("rst we_o", 32'(rwe_o), 0);
    chk("rst index_o", 32'(ridx_o), 0);
    chk("rst result_o", res_o, 0);
    chk("rst cyc", 32'(wb.wb_cyc_o), 0);
    chk("rst wb_we", 32'(wb.wb_we_o), 0);
    chk("rst sel", 32'(wb.wb_sel_o), 0);
    chk("rst adr", wb.wb_adr_o, 0);
    chk("rst dat", wb.wb_dat_o, 0);
    chk("rst misalign", 32'(mis), 0);
    chk("rst stall", 32'(stall), 0);
    rst = 1;

    // pass-through
    valid = 1; op = MEM_OP_NONE; res_i = 32'h12345678; ridx_i = 3; rwe_i = 1;
    #1 chk("pass stall", 32'(stall), 0);
    step();
    chk("pass result", res_o, 32'h12345678);
    chk("pass index", 32'(ridx_o), 3);
    chk("pass we", 32'(rwe_o), 1);
    res_i = 32'hCAFEF00D; ridx_i = 9; rwe_i = 0;
    step();
    valid = 0;
    step();
    chk("idle we", 32'(rwe_o), 0);

    // byte load, two wait states
    valid = 1; op = MEM_OP_LOAD; size = MEM_SIZE_BYTE; addr = 32'h101;
    rwe_i = 1; ridx_i = 5; rd = 32'hAABBCCDD;
    #1 chk("bl stall req", 32'(stall), 1);
    step();
    chk("bl adr", wb.wb_adr_o, 32'h100);
    chk("bl sel", 32'(wb.wb_sel_o), 32'h4);
    chk("bl stall w1", 32'(stall), 1);
    step();
    chk("bl stall w2", 32'(stall), 1);
    step();
    ack = 1;
    #1 chk("bl stall ack", 32'(stall), 0);
    step();
    ack = 0; valid = 0;
    chk("bl result", res_o, 32'h000000BB);
    chk("bl we", 32'(rwe_o), 1);
    chk("bl cyc", 32'(wb.wb_cyc_o), 0);
    step();
    chk("bl we once", 32'(rwe_o), 0);

    // back-to-back byte loads across every lane
    for (int a = 0; a < 4; a++) begin
      valid = 1; op = MEM_OP_LOAD; size = MEM_SIZE_BYTE; addr = 32'h20 + a;
      ridx_i = 4'(a + 1); rwe_i = 1;
      step();
      ack = 1;
      step();
      ack = 0;
      chk("byte lane", res_o, exp_b[a]);
    end
    // half loads, including one with addr[0] set
    rd = 32'h11223344;
    for (int a = 0; a < 4; a++) begin
      valid = 1; op = MEM_OP_LOAD; size = MEM_SIZE_HALF; addr = 32'h40 + a;
      step();
      if (wb.wb_cyc_o) begin
        ack = 1;
        step();
        ack = 0;
      end
    end
    valid = 0;
    step();

    // half store
    valid = 1; op = MEM_OP_STORE; size = MEM_SIZE_HALF; addr = 32'h202;
    sdata = 32'h0000BEEF; rwe_i = 1; ridx_i = 7;
    step();
    chk("hs dat", wb.wb_dat_o, 32'hBEEFBEEF);
    chk("hs sel", 32'(wb.wb_sel_o), 32'h3);
    chk("hs we", 32'(wb.wb_we_o), 1);
    chk("hs adr", wb.wb_adr_o, 32'h200);
    ack = 1;
    step();
    ack = 0; valid = 0;
    chk("hs no reg write", 32'(rwe_o), 0);
    step();

    // byte and word stores
    valid = 1; op = MEM_OP_STORE; size = MEM_SIZE_BYTE; addr = 32'h303; sdata = 32'h1234565A;
    step();
    chk("bs dat", wb.wb_dat_o, 32'h5A5A5A5A);
    chk("bs sel", 32'(wb.wb_sel_o), 32'h1);
    ack = 1; step(); ack = 0;
    size = MEM_SIZE_WORD; addr = 32'h400; sdata = 32'hDEADBEEF;
    step();
    ack = 1; step(); ack = 0; valid = 0;
    step();

    // misaligned word load
    valid = 1; op = MEM_OP_LOAD; size = MEM_SIZE_WORD; addr = 32'h3; rwe_i = 1; ridx_i = 9;
    rd = 32'h11223344;
`ifdef CPU_MEMORY_ALIGN_CHECK_EN
    #1 chk("mis stall", 32'(stall), 0);
    step();
    valid = 0;
    chk("mis flag", 32'(mis), 1);
    chk("mis cyc", 32'(wb.wb_cyc_o), 0);
    step();
    chk("mis flag once", 32'(mis), 0);
    chk("mis no write", 32'(rwe_o), 0);
`else
    #1 chk("mis stall", 32'(stall), 1);
    step();
    chk("mis adr", wb.wb_adr_o, 32'h0);
    chk("mis sel", 32'(wb.wb_sel_o), 32'hF);
    ack = 1;
    step();
    ack = 0; valid = 0;
    chk("mis result", res_o, 32'h11223344);
    chk("mis flag", 32'(mis), 0);
    step();
`endif

    // reset during a bus cycle, then a late ack
    valid = 1; op = MEM_OP_LOAD; size = MEM_SIZE_WORD; addr = 32'h40; rwe_i = 1; ridx_i = 4;
    step();
    chk("rm cyc before", 32'(wb.wb_cyc_o), 1);
    rst = 0;
    step();
    rst = 1; valid = 0;
    chk("rm cyc", 32'(wb.wb_cyc_o), 0);
    chk("rm stb", 32'(wb.wb_stb_o), 0);
    chk("rm we", 32'(rwe_o), 0);
    ack = 1; rd = 32'h55555555;
    step();
    ack = 0;
    chk("rm late ack we", 32'(rwe_o), 0);
    chk("rm late ack cyc", 32'(wb.wb_cyc_o), 0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
